// File: rtl/axi_stride_reader.sv
//------------------------------------------------------------------------------
// Module  : axi_stride_reader
// Purpose : AXI4 read initiator issuing a strided burst stream and sinking R beats
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module axi_stride_reader #(
  parameter int ADDR_BITS            = 64,
  parameter int BURST_LEN_WIDTH      = 8,
  parameter int TID_WIDTH            = 4,
  parameter int LOG_BLOCK_DATA_BYTES = 3,
  parameter int REQ_CNT_WIDTH        = 16,
  parameter int LOG_MAX_OUTSTANDING  = 2
) (
  input  logic                                   clk,
  input  logic                                   resetN,
  input  logic                                   en,
  input  logic                                   start,
  input  logic [ADDR_BITS-1:0]                   cfg_base,
  input  logic [ADDR_BITS-1:0]                   cfg_stride,
  input  logic [REQ_CNT_WIDTH-1:0]               cfg_reqCnt,
  input  logic [BURST_LEN_WIDTH-1:0]             cfg_len,
  input  logic [TID_WIDTH-1:0]                   cfg_id,
  output logic                                   m_ar_valid,
  input  logic                                   m_ar_ready,
  output logic [ADDR_BITS-1:0]                   m_ar_addr,
  output logic [BURST_LEN_WIDTH-1:0]             m_ar_len,
  output logic [TID_WIDTH-1:0]                   m_ar_id,
  input  logic                                   m_r_valid,
  output logic                                   m_r_ready,
  input  logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0]   m_r_data,
  input  logic                                   m_r_last,
  input  logic [TID_WIDTH-1:0]                   m_r_id,
  output logic                                   busy,
  output logic                                   done,
  output logic [REQ_CNT_WIDTH+BURST_LEN_WIDTH-1:0] beatCnt,
  output logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0]   checksum,
  output logic [2:0]                             errorCode
);

  localparam int c_data_bits = 8 << LOG_BLOCK_DATA_BYTES;
  localparam int c_out_bits  = LOG_MAX_OUTSTANDING + 1;
  localparam int c_cnt_bits  = REQ_CNT_WIDTH + BURST_LEN_WIDTH;
  localparam logic [c_out_bits-1:0] c_max_out = c_out_bits'(2 ** LOG_MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                       r_state, w_state_next;
  logic [ADDR_BITS-1:0]         r_addr, r_stride;
  logic [REQ_CNT_WIDTH-1:0]     r_req_cnt, r_issued;
  logic [BURST_LEN_WIDTH-1:0]   r_len, r_beat_idx, w_beat_idx_next;
  logic [TID_WIDTH-1:0]         r_id;
  logic [c_out_bits-1:0]        r_out, w_out_next;
  logic                         r_ar_hold;
  logic [c_cnt_bits-1:0]        r_beat_cnt;
  logic [c_data_bits-1:0]       r_checksum;
  logic [2:0]                   r_err, w_err_code;
  logic                         w_start_ok, w_busy, w_ar_valid, w_ar_hs, w_r_hs;
  logic                         w_last_close, w_final_ar;

  assign w_start_ok   = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
  // A raised valid is held by r_ar_hold even if en drops before the handshake.
  assign w_ar_valid   = r_ar_hold ||
                        (r_state == S_RUN && en && r_out < c_max_out && r_issued < r_req_cnt);
  assign w_ar_hs      = w_ar_valid && m_ar_ready;
  assign w_r_hs       = m_r_valid && w_busy;
  assign w_last_close = w_r_hs && m_r_last && (r_out != '0);
  assign w_final_ar   = w_ar_hs && (REQ_CNT_WIDTH'(r_issued + 1'b1) == r_req_cnt);

  always_comb begin
    w_out_next = r_out;
    if (w_ar_hs && !w_last_close)
      w_out_next = r_out + c_out_bits'(1);
    else if (!w_ar_hs && w_last_close)
      w_out_next = r_out - c_out_bits'(1);
  end

  // Beat index saturates at len when the last flag is missing, keeping the burst open.
  always_comb begin
    w_err_code      = 3'd0;
    w_beat_idx_next = r_beat_idx;
    if (w_r_hs) begin
      if (m_r_last)
        w_beat_idx_next = '0;
      else if (r_beat_idx != r_len)
        w_beat_idx_next = r_beat_idx + BURST_LEN_WIDTH'(1);
      if (m_r_last && r_beat_idx < r_len)
        w_err_code = 3'd1;
      else if (!m_r_last && r_beat_idx == r_len)
        w_err_code = 3'd2;
      else if (m_r_id != r_id)
        w_err_code = 3'd3;
      else if (r_out == '0)
        w_err_code = 3'd4;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_state_next = (cfg_reqCnt == '0) ? S_DONE : S_RUN;
      S_RUN:          if (w_final_ar) w_state_next = S_DRAIN;
      S_DRAIN:        if (w_out_next == '0) w_state_next = S_DONE;
      default:        w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_addr     <= '0;
      r_stride   <= '0;
      r_req_cnt  <= '0;
      r_len      <= '0;
      r_id       <= '0;
      r_issued   <= '0;
      r_out      <= '0;
      r_beat_idx <= '0;
      r_ar_hold  <= 1'b0;
      r_beat_cnt <= '0;
      r_checksum <= '0;
      r_err      <= 3'd0;
    end else if (w_start_ok) begin
      r_addr     <= cfg_base;
      r_stride   <= cfg_stride;
      r_req_cnt  <= cfg_reqCnt;
      r_len      <= cfg_len;
      r_id       <= cfg_id;
      r_issued   <= '0;
      r_out      <= '0;
      r_beat_idx <= '0;
      r_ar_hold  <= 1'b0;
      r_beat_cnt <= '0;
      r_checksum <= '0;
      r_err      <= 3'd0;
    end else begin
      if (w_ar_hs) begin
        r_addr   <= r_addr + r_stride;
        r_issued <= r_issued + REQ_CNT_WIDTH'(1);
      end
      r_ar_hold  <= w_ar_valid && !m_ar_ready;
      r_out      <= w_out_next;
      r_beat_idx <= w_beat_idx_next;
      if (w_r_hs) begin
        r_beat_cnt <= r_beat_cnt + c_cnt_bits'(1);
        r_checksum <= r_checksum ^ m_r_data;
        if (r_err == 3'd0)
          r_err <= w_err_code;
      end
    end
  end

  assign m_ar_valid = w_ar_valid;
  assign m_ar_addr  = r_addr;
  assign m_ar_len   = r_len;
  assign m_ar_id    = r_id;
  assign m_r_ready  = w_busy;
  assign busy       = w_busy;
  assign done       = (r_state == S_DONE);
  assign beatCnt    = r_beat_cnt;
  assign checksum   = r_checksum;
  assign errorCode  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_axi_stride_reader.sv
//------------------------------------------------------------------------------
// Module  : tb_axi_stride_reader
// Purpose : Self-checking bench with an AXI read responder and address/data model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_axi_stride_reader;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        en, start;
  logic [63:0] cfg_base, cfg_stride;
  logic [15:0] cfg_reqCnt;
  logic [7:0]  cfg_len;
  logic [3:0]  cfg_id;
  logic        m_ar_valid, m_ar_ready;
  logic [63:0] m_ar_addr;
  logic [7:0]  m_ar_len;
  logic [3:0]  m_ar_id;
  logic        m_r_valid, m_r_ready, m_r_last;
  logic [63:0] m_r_data;
  logic [3:0]  m_r_id;
  logic        busy, done;
  logic [23:0] beatCnt;
  logic [63:0] checksum;
  logic [2:0]  errorCode;

  always #5 clk = ~clk;

  axi_stride_reader dut (
    .clk(clk), .resetN(resetN), .en(en), .start(start),
    .cfg_base(cfg_base), .cfg_stride(cfg_stride), .cfg_reqCnt(cfg_reqCnt),
    .cfg_len(cfg_len), .cfg_id(cfg_id),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
    .m_ar_len(m_ar_len), .m_ar_id(m_ar_id),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data),
    .m_r_last(m_r_last), .m_r_id(m_r_id),
    .busy(busy), .done(done), .beatCnt(beatCnt), .checksum(checksum),
    .errorCode(errorCode)
  );

  typedef struct {
    logic [63:0] addr;
    int          nbeats;
    logic [3:0]  id;
  } burst_t;

  int          n_assert = 0;
  int          n_fail   = 0;
  burst_t      rq[$];
  logic [63:0] ar_log[$];
  logic        start_req = 0, en_req = 1, en_rand = 0, ar_rand = 0, r_rand = 0;
  logic        addr_data = 0, hold_r = 0, prev_pend = 0;
  int          ar_stall = 0, err_mode = 0;
  int          ar_total = 0, tb_out = 0, r_beat = 0;
  logic [63:0] exp_base, exp_stride, xor_model, prev_addr, golden;
  int          exp_req;
  logic [7:0]  exp_len;
  logic [3:0]  exp_id;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive the responder at the falling edge, then observe what the next rising edge will accept.
  task automatic tick();
    int     nb;
    logic [3:0] rid;
    @(negedge clk);
    start      = start_req;
    start_req  = 0;
    en         = en_rand ? ($urandom_range(0, 3) != 0) : en_req;
    m_ar_ready = (ar_stall > 0) ? 1'b0 : (ar_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    if (rq.size() > 0 && !hold_r && (!r_rand || $urandom_range(0, 1) == 1)) begin
      m_r_valid = 1'b1;
      m_r_id    = rq[0].id;
      m_r_last  = (r_beat == rq[0].nbeats - 1);
      m_r_data  = addr_data ? 64'(8'(rq[0].addr + 64'(r_beat * 8))) : {$urandom, $urandom};
    end else begin
      m_r_valid = 1'b0;
      m_r_last  = 1'b0;
      m_r_data  = '0;
    end
    #1;
    if (prev_pend) begin
      chk("ar_hold_valid", 64'(m_ar_valid), 1);
      chk("ar_hold_addr", m_ar_addr, prev_addr);
    end else if (!en || tb_out >= 4) begin
      chk("ar_gate", 64'(m_ar_valid), 0);
    end
    if (m_ar_valid && m_ar_ready) begin
      chk("ar_extra", 64'(ar_total < exp_req), 1);
      chk("ar_addr", m_ar_addr, exp_base + exp_stride * 64'(ar_total));
      chk("ar_len", 64'(m_ar_len), 64'(exp_len));
      chk("ar_id", 64'(m_ar_id), 64'(exp_id));
      nb  = int'(exp_len) + 1;
      rid = exp_id;
      if (err_mode == 1 && ar_total == 0) nb = 2;
      if (err_mode == 1 && ar_total == 1) rid = 4'd6;
      if (err_mode == 2 && ar_total == 0) nb = int'(exp_len) + 2;
      ar_log.push_back(m_ar_addr);
      rq.push_back('{m_ar_addr, nb, rid});
      ar_total++;
      tb_out++;
    end
    prev_pend = m_ar_valid && !m_ar_ready;
    prev_addr = m_ar_addr;
    if (m_r_valid && m_r_ready) begin
      xor_model ^= m_r_data;
      if (m_r_last) begin
        void'(rq.pop_front());
        r_beat = 0;
        tb_out--;
      end else begin
        r_beat++;
      end
    end
    if (ar_stall > 0) ar_stall--;
  endtask

  task automatic new_run(input logic [63:0] base, input logic [63:0] stride,
                         input int req, input logic [7:0] len, input logic [3:0] id);
    cfg_base = base;  cfg_stride = stride; cfg_reqCnt = 16'(req);
    cfg_len  = len;   cfg_id     = id;
    exp_base = base;  exp_stride = stride; exp_req = req; exp_len = len; exp_id = id;
    ar_total = 0; r_beat = 0; xor_model = '0;
    ar_log.delete();
    rq.delete();
    start_req = 1;
    tick();
  endtask

  task automatic run_done(input string tag, input int budget);
    int i = 0;
    do begin
      tick();
      i++;
    end while (!done && i < budget);
    chk({tag, "_done"}, 64'(done), 1);
  endtask

  task automatic wait_ar(input int n, input int budget);
    int i = 0;
    while (ar_total < n && i < budget) begin
      tick();
      i++;
    end
    chk("ar_wait", 64'(ar_total >= n), 1);
  endtask

  task automatic end_checks(input string tag, input int beats, input int err);
    chk({tag, "_beats"}, 64'(beatCnt), 64'(beats));
    chk({tag, "_csum"}, checksum, xor_model);
    chk({tag, "_err"}, 64'(errorCode), 64'(err));
    chk({tag, "_ars"}, 64'(ar_total), 64'(exp_req));
    chk({tag, "_busy"}, 64'(busy), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, 64'({m_ar_valid, m_r_ready, busy, done, errorCode}), 0);
    chk({tag, "_ar"}, m_ar_addr | 64'(m_ar_len) | 64'(m_ar_id), 0);
    chk({tag, "_cnt"}, 64'(beatCnt) | checksum, 0);
  endtask

  initial begin
    logic [63:0] exp_addr1 [4];
    int len_r, req_r;
    exp_addr1 = '{64'h100, 64'h140, 64'h180, 64'h1C0};
    start = 0; en = 1; m_ar_ready = 0; m_r_valid = 0; m_r_last = 0; m_r_data = '0; m_r_id = '0;
    cfg_base = '0; cfg_stride = '0; cfg_reqCnt = '0; cfg_len = '0; cfg_id = '0;
    exp_base = '0; exp_stride = '0; exp_req = 0; exp_len = '0; exp_id = '0;
    xor_model = '0; prev_addr = '0;
    tick();
    tick();
    chk_all_zero("reset");
    resetN = 1;

    // Directed run with zero-latency responder and address-byte data.
    addr_data = 1;
    new_run(64'h100, 64'h40, 4, 8'd3, 4'd5);
    tick();
    chk("first_valid", 64'(m_ar_valid), 1);
    run_done("t1", 200);
    golden = '0;
    for (int k = 0; k < 4; k++)
      for (int b = 0; b < 4; b++)
        golden ^= 64'(8'(64'h100 + 64'(k) * 64'h40 + 64'(b) * 8));
    chk("t1_golden", checksum, golden);
    for (int k = 0; k < 4; k++) chk("t1_addr_list", ar_log[k], exp_addr1[k]);
    end_checks("t1", 16, 0);
    addr_data = 0;

    // Outstanding limit: R held until the limit is reached.
    hold_r = 1;
    new_run(64'h2000, 64'h100, 6, 8'd1, 4'd3);
    wait_ar(4, 50);
    repeat (3) tick();
    chk("t2_stall_valid", 64'(m_ar_valid), 0);
    chk("t2_stall_ars", 64'(ar_total), 4);
    hold_r = 0;
    run_done("t2", 200);
    end_checks("t2", 12, 0);

    // Negative stride wraps through zero.
    new_run(64'h8, -64'sd16, 3, 8'd0, 4'd1);
    run_done("t3", 100);
    chk("t3_wrap_addr", ar_log[1], 64'hFFFF_FFFF_FFFF_FFF8);
    end_checks("t3", 3, 0);

    // AR ready stalled while en drops: valid and payload must hold.
    ar_stall = 6;
    new_run(64'h4000, 64'h80, 3, 8'd2, 4'd2);
    tick();
    chk("t4_valid_up", 64'(m_ar_valid), 1);
    en_req = 0;
    repeat (3) tick();
    chk("t4_valid_held", 64'(m_ar_valid), 1);
    chk("t4_no_hs", 64'(ar_total), 0);
    wait_ar(1, 10);
    repeat (4) tick();
    chk("t4_en_low_ars", 64'(ar_total), 1);
    en_req = 1;
    run_done("t4", 200);
    end_checks("t4", 9, 0);

    // Randomised runs with random ready, valid and enable.
    en_rand = 1; ar_rand = 1; r_rand = 1;
    for (int it = 0; it < 6; it++) begin
      req_r = int'($urandom_range(1, 7));
      len_r = int'($urandom_range(0, 4));
      new_run({$urandom, $urandom},
              (it % 2 == 1) ? {$urandom, $urandom} : -64'($urandom_range(1, 256)),
              req_r, 8'(len_r), 4'($urandom_range(0, 15)));
      run_done("rnd", 3000);
      end_checks("rnd", req_r * (len_r + 1), 0);
    end
    en_rand = 0; ar_rand = 0; r_rand = 0; en_req = 1;

    // Early last then wrong ID: first error sticks.
    err_mode = 1;
    new_run(64'h100, 64'h40, 2, 8'd3, 4'd5);
    run_done("e1", 200);
    end_checks("e1", 6, 1);
    // Missing last.
    err_mode = 2;
    new_run(64'h200, 64'h40, 1, 8'd1, 4'd5);
    run_done("e2", 200);
    end_checks("e2", 3, 2);
    err_mode = 0;

    // Reset in DRAIN, then a zero-length job.
    hold_r = 1;
    new_run(64'h300, 64'h10, 2, 8'd1, 4'd4);
    wait_ar(2, 50);
    tick();
    chk("t6_drain_busy", 64'(busy), 1);
    resetN = 0;
    #1;
    chk_all_zero("t6_async");
    rq.delete();
    tb_out = 0; r_beat = 0; hold_r = 0; prev_pend = 0;
    tick();
    chk_all_zero("t6_held");
    tick();
    resetN = 1;
    new_run(64'h500, 64'h10, 0, 8'd1, 4'd1);
    tick();
    chk("t6_zero_done", 64'(done), 1);
    chk("t6_zero_busy", 64'(busy), 0);
    repeat (4) tick();
    chk("t6_zero_ars", 64'(ar_total), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: observed no finish, expected finish within budget");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
